data_ram_bank: RTL and testbench
================================

# data_ram_bank

Parametrised, single-port, byte-masked data memory for the MEM stage. It is the next generation of the core's data RAM. It adds a registered read path, an accept/acknowledge handshake, out-of-range detection, and a hardware clear engine that zeroes the whole array after reset or on request. It sits between the MEM-stage load/store logic and the data bus.

## Interface
- DATA_WIDTH, 32: word width in bits; multiple of 8, from 8 to 128.
- DEPTH, 1024: number of words; power of 2, at least 2.
- ADDR_WIDTH, 32: byte-address width; at least log2(DEPTH)+log2(DATA_WIDTH/8).
- clk  in  1: single clock, all logic on the rising edge.
- rst  in  1: asynchronous, active-low reset.
- clr  in  1: synchronous request to re-zero the array.
- ce  in  1: access request.
- we  in  1: 1 = write, 0 = read.
- addr  in  ADDR_WIDTH: byte address.
- sel  in  DATA_WIDTH/8: byte enables; bit i selects data bits 8i+7:8i.
- data_i  in  DATA_WIDTH: write data.
- ready  out  1: an access can be accepted this cycle.
- ack  out  1: one-cycle pulse, the access accepted on the previous edge is complete.
- err  out  1: one-cycle pulse alongside ack, the accepted access was out of range.
- data_o  out  DATA_WIDTH: read data, valid on the ack of a read.

## Operation
- BYTES = DATA_WIDTH/8 and IW = log2(DEPTH).
- Word index = addr[IW+log2(BYTES)-1 : log2(BYTES)]. The low log2(BYTES) address bits are ignored.
- An address is out of range when any of addr[ADDR_WIDTH-1 : IW+log2(BYTES)] is nonzero.
- State machine with two states, INIT and RUN.
  - INIT:
    - A counter cnt walks 0..DEPTH-1 and writes all-zero to word cnt on each edge.
    - On the edge that clears word DEPTH-1, the state goes to RUN.
    - ready=0. Requests are ignored with no ack.
  - RUN: normal service.
    - clr=1 sends the state to INIT with cnt=0 on the next edge.
- ready = (state==RUN) & ~clr. It is combinational, so clr blocks acceptance in the same cycle.
- Accept condition: ce & ready at a rising edge.
- Accepted write, in range: each byte lane i with sel[i]=1 is written at that edge. Unselected lanes are unchanged. sel=0 still produces an ack.
- Accepted read, in range: data_o <= mem[index] at that edge.
- Accepted access, out of range:
  - Memory is unchanged.
  - data_o is unchanged.
  - ack=1 and err=1 on the next cycle.
- data_o holds its last read value until the next accepted in-range read. It is not zeroed by writes, idle cycles or clr.
- clr during INIT restarts the clear at cnt=0.

## Timing
- Reset (rst=0) immediately forces all of the following, and they hold while rst=0:
  - state=INIT, cnt=0
  - ready=0, ack=0, err=0
  - data_o=0
- Memory contents are undefined until INIT completes. Reset mid-access aborts it: no ack, and a write may be partially applied.
- After rst rises, the first edge clears word 0 and edge k clears word k-1. ready rises after edge DEPTH, i.e. DEPTH cycles of clearing.
- Latency is 1 cycle for both reads and writes. An access accepted at edge N gives ack=1 in the cycle after edge N, and data_o is valid in that same cycle for a read.
- Back-to-back accepts are allowed every cycle, giving one ack per accepted access.
- A write accepted at edge N followed by a read of the same word accepted at edge N+1 returns the new data. No hazard.
- clr and ce high in the same RUN cycle: clr wins, the request is not accepted and gets no ack. The ack for an access accepted at the previous edge still pulses.
- Inputs other than clr are don't-care when ce=0.

## Test plan
- Reset/clear:
  - DEPTH=16, DATA_WIDTH=32.
  - Release rst, hold ce=1 with we=0 throughout → ready=0 and no ack for 16 cycles; ready=1 after the 16th edge.
  - Read all 16 words → each returns 0x00000000 with ack 1 cycle later.
- Byte lanes:
  - Write 0xAABBCCDD with sel=1111 to addr 0x8.
  - Write 0x11223344 with sel=0101 to addr 0x8.
  - Read addr 0x8 → data_o=0xAA22CC44.
  - Also check addr 0xB maps to the same word.
- Pipelined traffic:
  - Back-to-back: write 0x5 to addr 0x4, read 0x4, read 0x0 on consecutive edges → 3 consecutive ack pulses; data_o=0x5, then 0x0.
- Out of range:
  - With DEPTH=16, write 0xFFFFFFFF to addr 0x40 → ack=1 and err=1.
  - Read addr 0x0 → unchanged, no alias.
  - Read addr 0x40 → err=1 and data_o holds its previous value.
- clr collision:
  - Memory nonzero, assert clr with ce=1/we=1 in the same cycle → that write gets no ack; ready=0 for 16 cycles.
  - Then every word reads 0.
- Reset mid-clear:
  - Drop rst at INIT cnt=7, re-release → a full 16-cycle clear restarts.
  - ack, err and data_o are 0 during reset.

Source files
------------

// File: rtl/data_ram_bank.sv
// Single-port byte-masked data RAM for the MEM stage: registered read, accept/ack
// handshake, out-of-range flagging and a zeroing engine that runs after reset or clr.

module data_ram_lane #(
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  // Array is left unreset; the clear engine defines its contents.
  always_ff @(posedge clk)
    if (wr) mem[idx] <= wdata;

  always_ff @(posedge clk or negedge rst)
    if (!rst)    rdata <= '0;
    else if (rd) rdata <= mem[idx];
endmodule

module data_ram_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    ce,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    ready,
  output logic                    ack,
  output logic                    err,
  output logic [DATA_WIDTH-1:0]   data_o
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BYTES);
  localparam logic [0:0]    INIT = 1'b0;
  localparam logic [0:0]    RUN  = 1'b1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  logic [0:0]            state;
  logic [IW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [ADDR_WIDTH-1:0] hi;
  logic                  oor;
  logic                  accept;
  logic                  initing;

  assign initing = (state == INIT);
  assign ready   = (state == RUN) & ~clr;
  assign accept  = ce & ready;
  assign hi      = addr >> (IW + BW);
  assign oor     = |hi;
  assign idx     = initing ? cnt : addr[IW+BW-1:BW];

  // clr takes priority in both states and always restarts the sweep at word 0.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= INIT;
      cnt   <= '0;
    end else if (clr) begin
      state <= INIT;
      cnt   <= '0;
    end else if (initing) begin
      cnt <= cnt + IW'(1);
      if (cnt == LAST) state <= RUN;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      ack <= accept;
      err <= accept & oor;
    end

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    logic       wr_l;
    logic       rd_l;
    logic [7:0] wd_l;
    assign wr_l = initing | (accept & we & ~oor & sel[i]);
    assign rd_l = accept & ~we & ~oor;
    assign wd_l = initing ? 8'h00 : data_i[8*i +: 8];

    data_ram_lane #(.DEPTH(DEPTH), .IW(IW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr_l),
      .rd    (rd_l),
      .idx   (idx),
      .wdata (wd_l),
      .rdata (data_o[8*i +: 8])
    );
  end
endmodule

// File: tb/tb_data_ram_bank.sv
// Bench for data_ram_bank (DEPTH=16, 32-bit words) with a word-array reference model.

module tb_data_ram_bank;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        ce  = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  sel  = '0;
  logic [31:0] data_i = '0;
  logic        ready, ack, err;
  logic [31:0] data_o;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] mem_m [16];
  int          init_left;
  logic        exp_ready, exp_ack, exp_err;
  logic [31:0] exp_data;
  logic        obs_ready, obs_ack, obs_err;
  logic [31:0] obs_data;

  data_ram_bank #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ce(ce), .we(we), .addr(addr),
    .sel(sel), .data_i(data_i), .ready(ready), .ack(ack), .err(err), .data_o(data_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    init_left = 16;
    exp_data  = '0;
    exp_ack   = 1'b0;
    exp_err   = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
  endtask

  // One clock: drive inputs, predict, clock, sample 1 time unit after the edge.
  task automatic cyc(input logic c, input logic w, input logic cl,
                     input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int wi;
    ce = c; we = w; clr = cl; addr = a; sel = s; data_i = d;
    #1;
    obs_ready = ready;
    exp_ready = (init_left == 0) && !cl;
    exp_ack   = c && exp_ready;
    exp_err   = exp_ack && (a >= 32'd64);
    wi = int'(a / 4) % 16;
    if (exp_ack && !exp_err) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mem_m[wi][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp_data = mem_m[wi];
      end
    end
    if (cl) begin
      init_left = 16;
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
    end else if (init_left > 0) begin
      init_left--;
    end
    @(posedge clk);
    #1;
    obs_ack = ack; obs_err = err; obs_data = data_o;
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b1; we = 1'b0;
    model_reset();
    #3;
    tests++;
    if ({ready, ack, err, data_o} !== 35'h0) begin
      fails++;
      $display("FAIL reset_outputs got ready=%b ack=%b err=%b data=%h want all 0", ready, ack, err, data_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'(k * 4), 4'hf, 32'h0);
      tests++;
      if ({obs_ready, obs_ack} !== 2'b00) begin
        fails++;
        $display("FAIL init_blocks cycle %0d got ready=%b ack=%b want 0 0", k, obs_ready, obs_ack);
      end
    end
    ce = 1'b0; #1;
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_init got %b want 1", ready);
    end
  endtask

  task automatic test_clear_reads();
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'(k * 4), 4'h0, 32'h0);
      tests++;
      if ({obs_ack, obs_err, obs_data} !== {2'b10, 32'h0}) begin
        fails++;
        $display("FAIL clear_read word %0d got ack=%b err=%b data=%h want 1 0 00000000", k, obs_ack, obs_err, obs_data);
      end
    end
  endtask

  task automatic test_byte_lanes();
    cyc(1'b1, 1'b1, 1'b0, 32'h8, 4'b1111, 32'hAABBCCDD);
    tests++;
    if ({obs_ack, obs_err} !== 2'b10) begin
      fails++;
      $display("FAIL lane_write_ack got ack=%b err=%b want 1 0", obs_ack, obs_err);
    end
    cyc(1'b1, 1'b1, 1'b0, 32'h8, 4'b0101, 32'h11223344);
    cyc(1'b1, 1'b0, 1'b0, 32'h8, 4'h0, 32'h0);
    tests++;
    if (obs_data !== 32'hAA22CC44) begin
      fails++;
      $display("FAIL lane_merge got %h want aa22cc44", obs_data);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'hB, 4'h0, 32'h0);
    tests++;
    if ({obs_ack, obs_data} !== {1'b1, 32'hAA22CC44}) begin
      fails++;
      $display("FAIL low_bits_ignored got ack=%b data=%h want 1 aa22cc44", obs_ack, obs_data);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b1, 1'b0, 32'h4, 4'hf, 32'h5);
    tests++;
    if (obs_ack !== 1'b1) begin
      fails++;
      $display("FAIL b2b_write_ack got %b want 1", obs_ack);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h4, 4'h0, 32'h0);
    tests++;
    if ({obs_ack, obs_data} !== {1'b1, 32'h5}) begin
      fails++;
      $display("FAIL b2b_read_new got ack=%b data=%h want 1 00000005", obs_ack, obs_data);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tests++;
    if ({obs_ack, obs_data} !== {1'b1, 32'h0}) begin
      fails++;
      $display("FAIL b2b_read_zero got ack=%b data=%h want 1 00000000", obs_ack, obs_data);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tests++;
    if (obs_ack !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_ack got %b want 0", obs_ack);
    end
  endtask

  task automatic test_out_of_range();
    cyc(1'b1, 1'b1, 1'b0, 32'h40, 4'hf, 32'hFFFFFFFF);
    tests++;
    if ({obs_ack, obs_err} !== 2'b11) begin
      fails++;
      $display("FAIL oor_write got ack=%b err=%b want 1 1", obs_ack, obs_err);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tests++;
    if ({obs_ack, obs_err, obs_data} !== {2'b10, 32'h0}) begin
      fails++;
      $display("FAIL oor_no_alias got ack=%b err=%b data=%h want 1 0 00000000", obs_ack, obs_err, obs_data);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h8, 4'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h40, 4'h0, 32'h0);
    tests++;
    if ({obs_ack, obs_err, obs_data} !== {2'b11, 32'hAA22CC44}) begin
      fails++;
      $display("FAIL oor_read_hold got ack=%b err=%b data=%h want 1 1 aa22cc44", obs_ack, obs_err, obs_data);
    end
  endtask

  task automatic test_clr_collision();
    cyc(1'b1, 1'b1, 1'b1, 32'h0, 4'hf, 32'hDEADBEEF);
    tests++;
    if ({obs_ready, obs_ack} !== 2'b00) begin
      fails++;
      $display("FAIL clr_wins got ready=%b ack=%b want 0 0", obs_ready, obs_ack);
    end
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'(k * 4), 4'hf, 32'hFFFF0000);
      tests++;
      if ({obs_ready, obs_ack} !== 2'b00) begin
        fails++;
        $display("FAIL clr_init cycle %0d got ready=%b ack=%b want 0 0", k, obs_ready, obs_ack);
      end
    end
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'(k * 4), 4'h0, 32'h0);
      tests++;
      if ({obs_ack, obs_data} !== {1'b1, 32'h0}) begin
        fails++;
        $display("FAIL clr_zeroed word %0d got ack=%b data=%h want 1 00000000", k, obs_ack, obs_data);
      end
    end
  endtask

  task automatic test_random();
    logic        c, w, cl;
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) == 1;
      cl = ($urandom_range(0, 79) == 0);
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      cyc(c, w, cl, a, 4'($urandom_range(0, 15)), $urandom);
      tests++;
      if ({obs_ready, obs_ack, obs_err, obs_data} !== {exp_ready, exp_ack, exp_err, exp_data}) begin
        fails++;
        $display("FAIL random step %0d got rdy=%b ack=%b err=%b data=%h want rdy=%b ack=%b err=%b data=%h",
                 n, obs_ready, obs_ack, obs_err, obs_data, exp_ready, exp_ack, exp_err, exp_data);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    // Finish any clear left running by the random phase.
    while (init_left > 0) cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h10, 4'hf, 32'h12345678);
    cyc(1'b1, 1'b0, 1'b0, 32'h10, 4'h0, 32'h0);
    tests++;
    if (obs_data !== 32'h12345678) begin
      fails++;
      $display("FAIL pre_reset_read got %h want 12345678", obs_data);
    end
    cyc(1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
    for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst = 1'b0;
    model_reset();
    #2;
    tests++;
    if ({ready, ack, err, data_o} !== 35'h0) begin
      fails++;
      $display("FAIL mid_clear_reset got ready=%b ack=%b err=%b data=%h want all 0", ready, ack, err, data_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h10, 4'h0, 32'h0);
      tests++;
      if ({obs_ready, obs_ack, obs_data} !== {2'b00, 32'h0}) begin
        fails++;
        $display("FAIL restart_clear cycle %0d got ready=%b ack=%b data=%h want 0 0 0", k, obs_ready, obs_ack, obs_data);
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h10, 4'h0, 32'h0);
    tests++;
    if ({obs_ready, obs_ack, obs_data} !== {2'b11, 32'h0}) begin
      fails++;
      $display("FAIL after_restart got ready=%b ack=%b data=%h want 1 1 00000000", obs_ready, obs_ack, obs_data);
    end
  endtask

  initial begin
    test_reset();
    test_clear_reads();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_clr_collision();
    test_random();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
